// File: rtl/argmax_pkg.sv
// Shared definitions for the argmax scheduler.
// Holds the FSM state encoding and the helpers that size the class-index
// and requester-id fields from the block parameters.
package argmax_pkg;

  // FSM state encoding
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SCAN = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Default configuration
  localparam int unsigned DEF_NUM_CLASSES = 10;
  localparam int unsigned DEF_NUM_REQ     = 2;

  // Width of a class index; NUM_CLASSES is at least 2, so this is at least 1
  function automatic int unsigned class_width(input int unsigned n);
    return $clog2(n);
  endfunction

  // Width of a requester id, never narrower than one bit
  function automatic int unsigned id_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  localparam int unsigned CLASS_W = class_width(DEF_NUM_CLASSES);
  localparam int unsigned ID_W    = id_width(DEF_NUM_REQ);

endpackage

// File: rtl/argmax_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter.
// Ports:
//   req        - request vector, one bit per requester
//   last_grant - index of the most recently served requester
//   grant      - one-hot grant; zero when no request is pending
//   grant_idx  - binary index of the granted requester
// Priority starts at last_grant+1 and wraps modulo NUM_REQ.
module rr_arbiter
  import argmax_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0]              req,
  input  logic [id_width(NUM_REQ)-1:0]    last_grant,
  output logic [NUM_REQ-1:0]              grant,
  output logic [id_width(NUM_REQ)-1:0]    grant_idx
);

  localparam int unsigned IW = id_width(NUM_REQ);

  logic          found;
  int unsigned   cand;
  logic [IW-1:0] cand_idx;

  // Walk requesters in rotated order; the first pending one wins
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand      = 0;
    cand_idx  = '0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      cand     = (32'(last_grant) + i) % NUM_REQ;
      cand_idx = IW'(cand);
      if (!found && req[cand_idx]) begin
        found           = 1'b1;
        grant[cand_idx] = 1'b1;
        grant_idx       = cand_idx;
      end
    end
  end

endmodule

// File: rtl/argmax_scheduler.sv
// Shared argmax engine serving several requesters.
// Ports:
//   clk, rst   - clock and synchronous active-high reset
//   req_valid  - request strobe per requester
//   req_ready  - one-hot accept, only ever high in IDLE
//   req_scores - packed score vectors, requester r in slice r,
//                class c at [c*BIT_SIZE +: BIT_SIZE] within the slice
//   res_valid  - result held while in DONE
//   res_ready  - result consumer accept
//   res_class  - winning class index (lowest index on ties)
//   res_id     - requester the result belongs to
//   res_max    - winning score
//   busy       - high whenever the engine is not IDLE
// A granted vector is captured, then scanned one class per cycle.
module argmax_scheduler
  import argmax_pkg::*;
#(
  parameter int unsigned BIT_SIZE    = 8,
  parameter int unsigned NUM_CLASSES = DEF_NUM_CLASSES,
  parameter int unsigned NUM_REQ     = DEF_NUM_REQ
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [NUM_REQ-1:0]                     req_valid,
  output logic [NUM_REQ-1:0]                     req_ready,
  input  logic [NUM_REQ*NUM_CLASSES*BIT_SIZE-1:0] req_scores,
  output logic                                   res_valid,
  input  logic                                   res_ready,
  output logic [class_width(NUM_CLASSES)-1:0]    res_class,
  output logic [id_width(NUM_REQ)-1:0]           res_id,
  output logic [BIT_SIZE-1:0]                    res_max,
  output logic                                   busy
);

  localparam int unsigned CW = class_width(NUM_CLASSES);
  localparam int unsigned IW = id_width(NUM_REQ);
  localparam logic [CW-1:0] LAST_CLASS = CW'(NUM_CLASSES - 1);
  localparam logic [IW-1:0] LAST_REQ   = IW'(NUM_REQ - 1);

  logic [1:0]          state_q, state_d;
  logic [CW-1:0]       count_q, count_d;
  logic [CW-1:0]       class_q, class_d;
  logic [IW-1:0]       id_q, id_d;
  logic [IW-1:0]       last_q, last_d;
  logic [BIT_SIZE-1:0] max_q, max_d;
  logic                load;

  logic [NUM_REQ-1:0]  grant;
  logic [IW-1:0]       grant_idx;
  logic [BIT_SIZE-1:0] scores [NUM_REQ][NUM_CLASSES];
  logic [BIT_SIZE-1:0] vec_q  [NUM_CLASSES];
  logic [BIT_SIZE-1:0] cur;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .req        (req_valid),
    .last_grant (last_q),
    .grant      (grant),
    .grant_idx  (grant_idx)
  );

  // Unpack the flat score bus into requester/class form
  always_comb begin
    for (int r = 0; r < int'(NUM_REQ); r++) begin
      for (int c = 0; c < int'(NUM_CLASSES); c++) begin
        scores[r][c] = req_scores[(r*int'(NUM_CLASSES)+c)*int'(BIT_SIZE) +: BIT_SIZE];
      end
    end
  end

  // Score under test this SCAN cycle
  assign cur = vec_q[count_q];

  // Next-state and datapath update
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    class_d = class_q;
    id_d    = id_q;
    last_d  = last_q;
    max_d   = max_q;
    load    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (|req_valid) begin
          load    = 1'b1;
          id_d    = grant_idx;
          last_d  = grant_idx;
          max_d   = scores[grant_idx][0];
          class_d = '0;
          count_d = CW'(1);
          state_d = ST_SCAN;
        end
      end
      ST_SCAN: begin
        // Strict compare keeps the earliest class on ties
        if (cur > max_q) begin
          max_d   = cur;
          class_d = count_q;
        end
        count_d = count_q + CW'(1);
        if (count_q == LAST_CLASS) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (res_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Control and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      class_q <= '0;
      id_q    <= '0;
      last_q  <= LAST_REQ;
      max_q   <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      class_q <= class_d;
      id_q    <= id_d;
      last_q  <= last_d;
      max_q   <= max_d;
    end
  end

  // Captured vector; contents are don't-care until the next load
  always_ff @(posedge clk) begin
    if (load && !rst) begin
      for (int c = 0; c < int'(NUM_CLASSES); c++) begin
        vec_q[c] <= scores[grant_idx][c];
      end
    end
  end

  assign req_ready = (state_q == ST_IDLE && !rst) ? grant : '0;
  assign res_valid = (state_q == ST_DONE);
  assign busy      = (state_q != ST_IDLE);
  assign res_class = class_q;
  assign res_id    = id_q;
  assign res_max   = max_q;

endmodule

// File: tb/tb_argmax_scheduler.sv
// Scoreboard bench for argmax_scheduler: stimulus pushes expected grants
// and results; a negedge monitor pops and compares them.
module tb_argmax_scheduler;

  localparam int BS = 8;
  localparam int NC = 10;
  localparam int NR = 2;

  logic               clk = 1'b0;
  logic               rst;
  logic [NR-1:0]      req_valid;
  logic [NR-1:0]      req_ready;
  logic [NR*NC*BS-1:0] req_scores;
  logic               res_valid;
  logic               res_ready;
  logic [3:0]         res_class;
  logic [0:0]         res_id;
  logic [7:0]         res_max;
  logic               busy;

  argmax_scheduler #(.BIT_SIZE(BS), .NUM_CLASSES(NC), .NUM_REQ(NR)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_scores (req_scores),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_class  (res_class),
    .res_id     (res_id),
    .res_max    (res_max),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int id;
    int cls;
    int mx;
  } exp_t;

  exp_t exp_q[$];
  int   grant_q[$];
  int   checks = 0;
  int   fails = 0;
  int   cyc = 0;
  int   xfer_cnt = 0;
  int   last_xfer = -1000;
  bit   chk_spacing = 1'b0;
  bit   prev_valid = 1'b0;

  int vec_a [NC] = '{3, 7, 1, 7, 0, 2, 9, 4, 9, 5};
  int vec_b [NC] = '{10, 20, 30, 40, 50, 60, 70, 80, 90, 100};
  int vec_c [NC] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
  int vec_d [NC] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 255};
  int vec_e [NC] = '{5, 5, 5, 5, 5, 5, 5, 5, 5, 5};
  int vec_f [NC] = '{200, 0, 0, 0, 0, 0, 0, 0, 0, 199};

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic set_vec(input int r, input int v [NC]);
    for (int c = 0; c < NC; c++) req_scores[(r*NC+c)*BS +: BS] = 8'(v[c]);
  endtask

  task automatic expect_res(input int g, input int cls, input int mx);
    exp_t e;
    e.id = g;
    e.cls = cls;
    e.mx = mx;
    grant_q.push_back(g);
    exp_q.push_back(e);
  endtask

  task automatic wait_xfers(input int n);
    int target;
    bit ok;
    target = xfer_cnt + n;
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(posedge clk);
      if (xfer_cnt >= target) ok = 1'b1;
    end
    #1;
    if (!ok) check("xfer_timeout", xfer_cnt, target);
  endtask

  task automatic wait_done();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(posedge clk);
      if (exp_q.size() == 0 && grant_q.size() == 0 && !busy) ok = 1'b1;
    end
    #1;
    if (!ok) begin
      check("done_timeout_pending", exp_q.size() + grant_q.size(), 0);
      exp_q.delete();
      grant_q.delete();
    end
  endtask

  always @(posedge clk) cyc++;

  // Monitor: grants, spacing, latency, result contents and hold
  always @(negedge clk) begin
    exp_t e;
    int g;
    if (rst) begin
      prev_valid = 1'b0;
    end else begin
      if (|(req_valid & req_ready)) begin
        g = req_ready[1] ? 1 : 0;
        check("ready_onehot", $countones(req_ready), 1);
        if (grant_q.size() == 0) check("unexpected_grant", g, -1);
        else check("grant_id", g, grant_q.pop_front());
        if (chk_spacing) check("xfer_spacing", cyc - last_xfer, 11);
        last_xfer = cyc;
        xfer_cnt++;
      end
      if (res_valid && !prev_valid) check("res_latency", cyc - last_xfer, 10);
      if (res_valid) begin
        check("ready_in_done", int'(req_ready), 0);
        if (exp_q.size() == 0) begin
          check("unexpected_result", int'(res_class), -1);
        end else begin
          e = exp_q[0];
          check("res_id", int'(res_id), e.id);
          check("res_class", int'(res_class), e.cls);
          check("res_max", int'(res_max), e.mx);
          if (res_ready) void'(exp_q.pop_front());
        end
      end
      prev_valid = res_valid;
    end
  end

  initial begin
    bit seen;
    rst = 1'b1;
    req_valid = 2'b11;
    res_ready = 1'b1;
    req_scores = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("ready_in_reset", int'(req_ready), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_valid", int'(res_valid), 0);
    check("reset_class", int'(res_class), 0);
    check("reset_max", int'(res_max), 0);
    check("reset_id", int'(res_id), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    req_valid = 2'b00;

    // Single request from requester 0
    set_vec(0, vec_a);
    expect_res(0, 6, 9);
    req_valid = 2'b01;
    wait_xfers(1);
    req_valid = 2'b00;
    wait_done();

    // Single request from requester 1
    set_vec(1, vec_b);
    expect_res(1, 9, 100);
    req_valid = 2'b10;
    wait_xfers(1);
    req_valid = 2'b00;
    wait_done();

    // Both requesting continuously: alternate 0,1,0,1 every 11 cycles
    expect_res(0, 6, 9);
    expect_res(1, 9, 100);
    expect_res(0, 6, 9);
    expect_res(1, 9, 100);
    req_valid = 2'b11;
    wait_xfers(1);
    chk_spacing = 1'b1;
    wait_xfers(3);
    chk_spacing = 1'b0;
    req_valid = 2'b00;
    wait_done();

    // Backpressure in DONE with requester 0 waiting
    res_ready = 1'b0;
    set_vec(1, vec_c);
    expect_res(1, 0, 0);
    req_valid = 2'b10;
    wait_xfers(1);
    set_vec(0, vec_d);
    expect_res(0, 9, 255);
    req_valid = 2'b01;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (res_valid) seen = 1'b1;
    end
    check("bp_res_valid_seen", int'(seen), 1);
    repeat (5) @(posedge clk);
    #1;
    res_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("bp_released", int'(res_valid), 0);
    check("bp_idle_ready", int'(req_ready), 1);
    wait_xfers(1);
    req_valid = 2'b00;
    wait_done();

    // Requester 0 pulses while engine busy: no grant for it
    set_vec(1, vec_e);
    expect_res(1, 0, 5);
    req_valid = 2'b10;
    wait_xfers(1);
    set_vec(0, vec_a);
    req_valid = 2'b01;
    repeat (3) @(posedge clk);
    #1;
    req_valid = 2'b00;
    wait_done();

    // Reset at count 4 of a scan from requester 0
    set_vec(0, vec_f);
    grant_q.push_back(0);
    req_valid = 2'b01;
    wait_xfers(1);
    req_valid = 2'b00;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    set_vec(1, vec_b);
    req_valid = 2'b11;
    @(negedge clk);
    check("rst_ready_zero", int'(req_ready), 0);
    @(posedge clk);
    @(negedge clk);
    check("abort_busy", int'(busy), 0);
    check("abort_valid", int'(res_valid), 0);
    check("abort_max", int'(res_max), 0);
    check("abort_ready_zero", int'(req_ready), 0);
    @(posedge clk);
    #1;
    expect_res(0, 0, 200);
    rst = 1'b0;
    wait_xfers(1);
    req_valid = 2'b00;
    wait_done();

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
